// File: rtl/rv_mdu.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide.
// Fixed latency of XLEN+3 cycles from an accepted start to the done pulse.
module rv_mdu #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] opa,
   input  logic [XLEN-1:0] opb,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int unsigned CntW = $clog2(XLEN);

   typedef enum logic [2:0] {StIdle, StPrep, StCalc, StFix, StDone} state_e;

   state_e              state_q, state_d;
   logic [2:0]          op_q;
   logic [XLEN-1:0]     a_q, b_q, result_q;
   logic                sign_a_q, sign_b_q;
   logic [2*XLEN-1:0]   acc_q;
   logic [CntW-1:0]     cnt_q;

   logic                accept, last_iter, is_div;
   logic                a_signed, b_signed, neg_a, neg_b;
   logic [XLEN-1:0]     mag_a, mag_b;
   logic [XLEN:0]       mul_sum, rem_sh, div_diff;
   logic [2*XLEN-1:0]   mul_next, div_next, prod;
   logic [XLEN-1:0]     quo, rem, fix_result;
   logic                q_neg;

   assign accept    = start && ((state_q == StIdle) || (state_q == StDone));
   assign last_iter = (cnt_q == CntW'(XLEN - 1));
   assign is_div    = op_q[2];

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept) state_d = StPrep;
         StPrep:  state_d = StCalc;
         StCalc:  if (last_iter) state_d = StFix;
         StFix:   state_d = StDone;
         StDone:  state_d = accept ? StPrep : StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   // Operand signedness; MULHSU treats only rs1 as signed.
   always_comb begin
      a_signed = 1'b0;
      b_signed = 1'b0;
      unique case (op_q)
         3'd0, 3'd1, 3'd4, 3'd6: begin
            a_signed = 1'b1;
            b_signed = 1'b1;
         end
         3'd2:    a_signed = 1'b1;
         default: ;
      endcase
   end

   assign neg_a = a_signed && a_q[XLEN-1];
   assign neg_b = b_signed && b_q[XLEN-1];
   assign mag_a = neg_a ? -a_q : a_q;
   assign mag_b = neg_b ? -b_q : b_q;

   // Multiply: low half of acc holds the multiplier, high half the partial product.
   assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? a_q : {XLEN{1'b0}})};
   assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

   // Divide: high half is the partial remainder, low half shifts dividend out / quotient in.
   assign rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
   assign div_diff = rem_sh - {1'b0, b_q};
   assign div_next = div_diff[XLEN]
                   ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                   : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

   assign prod  = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
   assign quo   = acc_q[XLEN-1:0];
   assign rem   = acc_q[2*XLEN-1:XLEN];
   // b_q holds the divisor magnitude here, so this also suppresses negation on divide-by-zero.
   assign q_neg = (sign_a_q ^ sign_b_q) && (b_q != {XLEN{1'b0}});

   always_comb begin
      fix_result = {XLEN{1'b0}};
      unique case (op_q)
         3'd0:             fix_result = prod[XLEN-1:0];
         3'd1, 3'd2, 3'd3: fix_result = prod[2*XLEN-1:XLEN];
         3'd4, 3'd5:       fix_result = q_neg ? -quo : quo;
         3'd6, 3'd7:       fix_result = sign_a_q ? -rem : rem;
         default:          fix_result = {XLEN{1'b0}};
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q     <= 3'd0;
         a_q      <= {XLEN{1'b0}};
         b_q      <= {XLEN{1'b0}};
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         acc_q    <= {2*XLEN{1'b0}};
         cnt_q    <= {CntW{1'b0}};
         result_q <= {XLEN{1'b0}};
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               if (accept) begin
                  op_q <= funct3;
                  a_q  <= opa;
                  b_q  <= opb;
               end
            end
            StPrep: begin
               sign_a_q <= neg_a;
               sign_b_q <= neg_b;
               a_q      <= mag_a;
               b_q      <= mag_b;
               acc_q    <= is_div ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
               cnt_q    <= {CntW{1'b0}};
            end
            StCalc: begin
               acc_q <= is_div ? div_next : mul_next;
               cnt_q <= cnt_q + CntW'(1);
            end
            StFix:   result_q <= fix_result;
            default: ;
         endcase
      end
   end

   assign busy   = (state_q == StPrep) || (state_q == StCalc) || (state_q == StFix);
   assign done   = (state_q == StDone);
   assign result = result_q;

endmodule
